// File: rtl/tile_pkg.sv
// Shared types and constants for the tile renderer / video RAM arbitration path.
package tile_pkg;

  localparam int unsigned RAM_AW        = 16;
  localparam int unsigned RAM_DW        = 16;
  // Cycles between renderer busy rising and its first RAM address.
  localparam int unsigned VID_BUSY_LEAD = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/tile_ram_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/tile_ram_arbiter.sv
// Shares the video RAM between the tile renderer (always wins) and a CPU requester.
module tile_ram_arbiter
  import tile_pkg::*;
#(
  parameter int unsigned AW    = RAM_AW,
  parameter int unsigned DW    = RAM_DW,
  parameter int unsigned WAITW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vid_busy,
  input  logic [AW-1:0]    vid_addr,
  output logic [DW-1:0]    vid_read,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [DW-1:0]    cpu_wdata,
  output logic             cpu_ack,
  output logic [DW-1:0]    cpu_rdata,
  output logic [WAITW-1:0] cpu_wait,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_din,
  output logic             ram_we,
  input  logic [DW-1:0]    ram_dout
);

  arb_state_t    state;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_data;
  logic          lat_we;
  logic          blocked;

  // Accepting only while video is idle leaves the renderer's busy lead as guard time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_we    <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req && !vid_busy && !cpu_ack) begin
            lat_addr <= cpu_addr;
            lat_data <= cpu_wdata;
            lat_we   <= cpu_we;
            state    <= ADDR;
          end
        end
        ADDR: state <= DATA;
        DATA: begin
          if (!lat_we) begin
            cpu_rdata <= ram_dout;
          end
          cpu_ack <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM port belongs to the CPU only during ADDR; decoded from state so reset drops ram_we at once.
  always_comb begin
    ram_addr = vid_addr;
    ram_din  = '0;
    ram_we   = 1'b0;
    if (state == ADDR) begin
      ram_addr = lat_addr;
      ram_din  = lat_data;
      ram_we   = lat_we;
    end
  end

  assign vid_read = ram_dout;
  assign blocked  = (state == IDLE) && cpu_req && !cpu_ack && vid_busy;

  sat_counter #(
    .W(WAITW)
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (blocked),
    .clear (1'b0),
    .count (cpu_wait)
  );

endmodule
